// File: rtl/qpsk_symbol_detector_if.sv
// Sample-stream and decision bus of the QPSK symbol detector.
// master = sample source / decision consumer, slave = detector.
// Optional macro QPSK_DET_SOFT_EN adds the soft_i/soft_q decision metrics.
interface qpsk_symbol_detector_if;
   logic       [3:0]  sample_in;
   logic              sample_valid;
   logic              sample_ready;
   logic              sym_start;
   logic       [1:0]  dibit;
   logic              dibit_valid;
   logic              sync_err;
`ifdef QPSK_DET_SOFT_EN
   logic signed [11:0] soft_i;
   logic signed [11:0] soft_q;

   modport master (
      output sample_in, sample_valid, sym_start,
      input  sample_ready, dibit, dibit_valid, sync_err, soft_i, soft_q
   );

   modport slave (
      input  sample_in, sample_valid, sym_start,
      output sample_ready, dibit, dibit_valid, sync_err, soft_i, soft_q
   );
`else
   modport master (
      output sample_in, sample_valid, sym_start,
      input  sample_ready, dibit, dibit_valid, sync_err
   );

   modport slave (
      input  sample_in, sample_valid, sym_start,
      output sample_ready, dibit, dibit_valid, sync_err
   );
`endif
endinterface

// File: rtl/qpsk_symbol_detector.sv
// QPSK symbol detector: correlates 16 carrier samples per symbol against
// cosine/sine references and decides the dibit from the signs of the sums.
// Optional macro QPSK_DET_SOFT_EN exports the 12-bit correlation sums.
module qpsk_symbol_detector #(
   parameter int SPS = 16
) (
   input logic                   clk,
   input logic                   rst,
   qpsk_symbol_detector_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCUM  = 2'd1;
   localparam logic [1:0] DECIDE = 2'd2;

   localparam logic [3:0] K_LAST = 4'(SPS - 1);

   logic        [1:0]  state;
   logic        [3:0]  k;
   logic signed [11:0] acc_i;
   logic signed [11:0] acc_q;
   logic signed [4:0]  s;
   logic signed [3:0]  cos_c;
   logic signed [3:0]  sin_c;
   logic signed [11:0] prod_i;
   logic signed [11:0] prod_q;
   logic signed [11:0] sum_i;
   logic signed [11:0] sum_q;
   logic        [1:0]  dibit_r;
   logic               dibit_valid_r;
   logic               sync_err_r;
   logic               xfer;

   assign bus.sample_ready = (state != DECIDE);
   assign xfer             = bus.sample_valid & bus.sample_ready;

   // Offset-binary sample to signed, midscale 8 maps to zero.
   assign s = $signed({1'b0, bus.sample_in}) - 5'sd8;

   // Reference tables indexed by the sample position within the symbol.
   always_comb begin
      cos_c = 4'sd0;
      sin_c = 4'sd0;
      case (k)
         4'd0:  begin cos_c =  4'sd7; sin_c =  4'sd0; end
         4'd1:  begin cos_c =  4'sd6; sin_c =  4'sd3; end
         4'd2:  begin cos_c =  4'sd5; sin_c =  4'sd5; end
         4'd3:  begin cos_c =  4'sd3; sin_c =  4'sd6; end
         4'd4:  begin cos_c =  4'sd0; sin_c =  4'sd7; end
         4'd5:  begin cos_c = -4'sd3; sin_c =  4'sd6; end
         4'd6:  begin cos_c = -4'sd5; sin_c =  4'sd5; end
         4'd7:  begin cos_c = -4'sd6; sin_c =  4'sd3; end
         4'd8:  begin cos_c = -4'sd7; sin_c =  4'sd0; end
         4'd9:  begin cos_c = -4'sd6; sin_c = -4'sd3; end
         4'd10: begin cos_c = -4'sd5; sin_c = -4'sd5; end
         4'd11: begin cos_c = -4'sd3; sin_c = -4'sd6; end
         4'd12: begin cos_c =  4'sd0; sin_c = -4'sd7; end
         4'd13: begin cos_c =  4'sd3; sin_c = -4'sd6; end
         4'd14: begin cos_c =  4'sd5; sin_c = -4'sd5; end
         default: begin cos_c = 4'sd6; sin_c = -4'sd3; end
      endcase
   end

   // A restart forces k to 0, so the products always use the k=0 reference.
   logic signed [3:0] cos_use;
   logic signed [3:0] sin_use;
   logic              restart;

   assign restart = bus.sym_start & ((state == IDLE) | (k != 4'd0));
   assign cos_use = restart ? 4'sd7 : cos_c;
   assign sin_use = restart ? 4'sd0 : sin_c;
   assign prod_i  = 12'(s) * 12'(cos_use);
   assign prod_q  = 12'(s) * 12'(sin_use);
   assign sum_i   = acc_i + prod_i;
   assign sum_q   = acc_q + prod_q;

`ifdef QPSK_DET_SOFT_EN
   logic signed [11:0] soft_i_r;
   logic signed [11:0] soft_q_r;

   assign bus.soft_i = soft_i_r;
   assign bus.soft_q = soft_q_r;

   // Soft metrics are captured alongside the hard decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         soft_i_r <= '0;
         soft_q_r <= '0;
      end else if (state == ACCUM && xfer && !restart && k == K_LAST) begin
         soft_i_r <= sum_i;
         soft_q_r <= sum_q;
      end
   end
`endif

   assign bus.dibit       = dibit_r;
   assign bus.dibit_valid = dibit_valid_r;
   assign bus.sync_err    = sync_err_r;

   // Symbol FSM; the decision is registered on the final sample's transfer
   // so dibit and its valid pulse coincide with the one-cycle DECIDE state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         k             <= 4'd0;
         acc_i         <= '0;
         acc_q         <= '0;
         dibit_r       <= 2'b00;
         dibit_valid_r <= 1'b0;
         sync_err_r    <= 1'b0;
      end else begin
         dibit_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer && bus.sym_start) begin
                  acc_i <= prod_i;
                  acc_q <= prod_q;
                  k     <= 4'd1;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  if (restart) begin
                     acc_i      <= prod_i;
                     acc_q      <= prod_q;
                     k          <= 4'd1;
                     sync_err_r <= 1'b1;
                  end else begin
                     acc_i <= sum_i;
                     acc_q <= sum_q;
                     k     <= k + 4'd1;
                     if (k == K_LAST) begin
                        dibit_r       <= {sum_i[11], sum_q[11]};
                        dibit_valid_r <= 1'b1;
                        state         <= DECIDE;
                     end
                  end
               end
            end
            DECIDE: begin
               acc_i <= '0;
               acc_q <= '0;
               k     <= 4'd0;
               state <= ACCUM;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
